// File: rtl/guess_checker.sv
// guess_checker: front end of the password game.
// Synchronises and debounces the active-low submit button, latches one guess
// per press, compares it with SECRET to produce high/low/bingo hints, counts
// remaining attempts and locks the round on exhaustion or timeout.
//
// Configuration macro: GUESS_CHECKER_DEBOUNCE_EN
//   defined   -> the synchronised button must be stable for DEB_CYCLES clocks
//                before the debounced level follows it.
//   undefined -> the debounced level is the synchroniser output itself
//                (2-cycle press latency, every synced falling edge submits).
module guess_checker #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned MAX_TRIES  = 5,
    parameter logic [7:0]  SECRET     = 8'hB5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [7:0] sw,
    input  logic       timeout,
    input  logic       new_round,
    output logic       hint_hi,
    output logic       hint_lo,
    output logic       bingo_pulse,
    output logic       locked,
    output logic       won,
    output logic [3:0] tries_left,
    output logic [7:0] last_guess
);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        EVAL   = 2'd1,
        WON    = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_deb_d;
    logic w_deb;
    logic w_submit;

    // Two-flop synchroniser; btn_n is asynchronous to clk, idle level is high.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of order.
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GUESS_CHECKER_DEBOUNCE_EN
    localparam int unsigned    CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_deb_cnt;
    logic             r_deb;

    // Debounce: count consecutive cycles the synced level disagrees with the
    // debounced level; adopt it once it has disagreed for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == CNT_LAST) begin
            r_deb     <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_deb = r_deb;
`else
    // Without debounce the synchroniser output is the debounced level.
    assign w_deb = r_sync2;

    logic w_unused_deb;
    assign w_unused_deb = ^DEB_CYCLES;
`endif

    // Previous debounced level, used to detect the released->pressed edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_d <= 1'b1;
        end else begin
            r_deb_d <= w_deb;
        end
    end

    // One-cycle submit on the high->low transition of the debounced level.
    assign w_submit = r_deb_d & ~w_deb;

    // ------------------------------------------------------------------
    // Round control
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_tries;
    logic [3:0] w_tries_nxt;
    logic [3:0] w_tries_dec;
    logic       r_hint_hi;
    logic       w_hint_hi_nxt;
    logic       r_hint_lo;
    logic       w_hint_lo_nxt;
    logic       r_bingo;
    logic       w_bingo_nxt;
    logic       r_won;
    logic       r_locked;
    logic [7:0] r_guess;
    logic [7:0] w_guess_nxt;
    logic       w_guess_gt;
    logic       w_guess_eq;

    assign w_guess_gt  = (r_guess > SECRET);
    assign w_guess_eq  = (r_guess == SECRET);
    // Saturating decrement: the attempt counter can never wrap below zero.
    assign w_tries_dec = (r_tries == 4'd0) ? 4'd0 : (r_tries - 4'd1);

    // Next-state, hint, attempt and guess logic; priority new_round > timeout > submit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_tries_nxt   = r_tries;
        w_hint_hi_nxt = r_hint_hi;
        w_hint_lo_nxt = r_hint_lo;
        w_guess_nxt   = r_guess;
        w_bingo_nxt   = 1'b0;

        if (new_round) begin
            w_state_nxt   = READY;
            w_tries_nxt   = TRIES_INIT;
            w_hint_hi_nxt = 1'b0;
            w_hint_lo_nxt = 1'b0;
        end else begin
            case (r_state)
                READY: begin
                    if (timeout) begin
                        w_state_nxt = LOCKED;
                    end else if (w_submit) begin
                        w_guess_nxt = sw;
                        w_state_nxt = EVAL;
                    end
                end

                EVAL: begin
                    // Hints are always updated, even when timeout pre-empts.
                    w_hint_hi_nxt = w_guess_gt | w_guess_eq;
                    w_hint_lo_nxt = ~w_guess_gt;
                    if (w_guess_eq) begin
                        // A correct guess beats a simultaneous timeout.
                        w_bingo_nxt = 1'b1;
                        w_state_nxt = WON;
                    end else begin
                        w_tries_nxt = w_tries_dec;
                        if ((w_tries_dec == 4'd0) || timeout) begin
                            w_state_nxt = LOCKED;
                        end else begin
                            w_state_nxt = READY;
                        end
                    end
                end

                default: begin
                    // WON and LOCKED wait for new_round; submit and timeout ignored.
                end
            endcase
        end
    end

    // Round state, hints, attempts and latched guess registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= READY;
            r_tries   <= TRIES_INIT;
            r_hint_hi <= 1'b0;
            r_hint_lo <= 1'b0;
            r_bingo   <= 1'b0;
            r_won     <= 1'b0;
            r_locked  <= 1'b0;
            r_guess   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_tries   <= w_tries_nxt;
            r_hint_hi <= w_hint_hi_nxt;
            r_hint_lo <= w_hint_lo_nxt;
            r_bingo   <= w_bingo_nxt;
            r_won     <= (w_state_nxt == WON);
            r_locked  <= (w_state_nxt == LOCKED);
            r_guess   <= w_guess_nxt;
        end
    end

    assign hint_hi     = r_hint_hi;
    assign hint_lo     = r_hint_lo;
    assign bingo_pulse = r_bingo;
    assign locked      = r_locked;
    assign won         = r_won;
    assign tries_left  = r_tries;
    assign last_guess  = r_guess;

endmodule

// File: tb/tb_guess_checker.sv
// tb_guess_checker: directed stimulus for guess_checker with a cycle-level
// behavioural model of the game rules and hand-computed literal checkpoints.
// Works with GUESS_CHECKER_DEBOUNCE_EN either defined or undefined.
`timescale 1ns/1ps
module tb_guess_checker;

    localparam int         DEB    = 4;
    localparam int         MAXT   = 3;
    localparam logic [7:0] SEC    = 8'hB5;
    localparam int         SETTLE = 14;
    localparam int         BOUND  = 60;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_n     = 1'b1;
    logic [7:0] sw        = 8'h00;
    logic       timeout   = 1'b0;
    logic       new_round = 1'b0;
    logic       hint_hi;
    logic       hint_lo;
    logic       bingo_pulse;
    logic       locked;
    logic       won;
    logic [3:0] tries_left;
    logic [7:0] last_guess;

    guess_checker #(
        .DEB_CYCLES(DEB),
        .MAX_TRIES (MAXT),
        .SECRET    (SEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .sw         (sw),
        .timeout    (timeout),
        .new_round  (new_round),
        .hint_hi    (hint_hi),
        .hint_lo    (hint_lo),
        .bingo_pulse(bingo_pulse),
        .locked     (locked),
        .won        (won),
        .tries_left (tries_left),
        .last_guess (last_guess)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: game rules applied once per clock edge.
    // ------------------------------------------------------------------
    bit         m_valid = 1'b0;
    logic       m_hi, m_lo, m_bingo, m_won, m_locked;
    int         m_tries;
    logic [7:0] m_guess;
    bit         m_pending;      // a guess is latched and awaits its verdict
    bit         m_deb, m_deb_prev, m_submit_now;
    bit         btn_q[$];       // btn_n as seen at each edge, newest last

    always @(posedge clk) begin
        if (rst) begin
            m_valid   = 1'b1;
            m_hi      = 1'b0;
            m_lo      = 1'b0;
            m_bingo   = 1'b0;
            m_won     = 1'b0;
            m_locked  = 1'b0;
            m_tries   = MAXT;
            m_guess   = 8'h00;
            m_pending = 1'b0;
            btn_q.delete();
            for (int i = 0; i < 8; i++) btn_q.push_back(1'b1);
            m_deb        = 1'b1;
            m_deb_prev   = 1'b1;
            m_submit_now = 1'b0;
        end else begin
            bit submit;
            bit new_deb;
            int n;
            submit  = m_submit_now;
            m_bingo = 1'b0;
            if (new_round) begin
                m_won = 1'b0; m_locked = 1'b0; m_pending = 1'b0;
                m_tries = MAXT; m_hi = 1'b0; m_lo = 1'b0;
            end else if (m_won || m_locked) begin
                // round over: only new_round matters
            end else if (m_pending) begin
                m_pending = 1'b0;
                m_hi = (m_guess >= SEC);
                m_lo = (m_guess <= SEC);
                if (m_guess == SEC) begin
                    m_won = 1'b1; m_bingo = 1'b1;
                end else begin
                    if (m_tries > 0) m_tries--;
                    if (m_tries == 0 || timeout) m_locked = 1'b1;
                end
            end else if (timeout) begin
                m_locked = 1'b1;
            end else if (submit) begin
                m_guess = sw; m_pending = 1'b1;
            end

            // Button: synced level is btn_n from two edges back.
            btn_q.push_back(btn_n);
            if (btn_q.size() > 16) btn_q.delete(0);
            n = btn_q.size();
`ifdef GUESS_CHECKER_DEBOUNCE_EN
            // Follow the synced level once its last DEB samples all disagree.
            new_deb = ~m_deb;
            for (int i = 0; i < DEB; i++)
                if (btn_q[n - 3 - i] == m_deb) new_deb = m_deb;
`else
            new_deb = btn_q[n - 2];
`endif
            m_deb_prev   = m_deb;
            m_deb        = new_deb;
            m_submit_now = m_deb_prev & ~m_deb;
        end
    end

    // Compare every output against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            check("hint_hi",     32'(hint_hi),     32'(m_hi));
            check("hint_lo",     32'(hint_lo),     32'(m_lo));
            check("bingo_pulse", 32'(bingo_pulse), 32'(m_bingo));
            check("won",         32'(won),         32'(m_won));
            check("locked",      32'(locked),      32'(m_locked));
            check("tries_left",  32'(tries_left),  m_tries);
            check("last_guess",  32'(last_guess),  32'(m_guess));
        end
    end

    int bingo_cnt = 0;
    always @(negedge clk) if (bingo_pulse === 1'b1) bingo_cnt++;

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] g, input int low_cycles);
        sw    = g;
        btn_n = 1'b0;
        tick(low_cycles);
        btn_n = 1'b1;
        tick(SETTLE);
    endtask

    task automatic pulse_new_round();
        new_round = 1'b1;
        tick(1);
        new_round = 1'b0;
        tick(2);
    endtask

    task automatic wait_submit();
        int n = 0;
        while (!m_submit_now && n < BOUND) begin tick(1); n++; end
        check("wait_submit", 32'(m_submit_now), 1);
    endtask

    task automatic wait_pending();
        int n = 0;
        while (!m_pending && n < BOUND) begin tick(1); n++; end
        check("wait_eval", 32'(m_pending), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        rst = 1'b1; tick(3); rst = 1'b0; tick(3);
        check("rst_tries", 32'(tries_left), 3);
        check("rst_guess", 32'(last_guess), 0);
        check("rst_flags", {hint_hi, hint_lo, bingo_pulse, locked, won}, 0);

        // Long press with a high guess: exactly one submit.
        press(8'hC0, 10);
        check("g1_guess", 32'(last_guess), 32'h00C0);
        check("g1_hints", {hint_hi, hint_lo}, 2'b10);
        check("g1_tries", 32'(tries_left), 2);

        // Bouncy press of a low guess (clean press when debounce is absent).
`ifdef GUESS_CHECKER_DEBOUNCE_EN
        sw = 8'h10;
        btn_n = 1'b0; tick(2); btn_n = 1'b1; tick(1);
        btn_n = 1'b0; tick(10); btn_n = 1'b1; tick(SETTLE);
`else
        press(8'h10, 10);
`endif
        check("g2_guess", 32'(last_guess), 32'h0010);
        check("g2_hints", {hint_hi, hint_lo}, 2'b01);
        check("g2_tries", 32'(tries_left), 1);

        // Third wrong guess exhausts the round; a fourth press is ignored.
        press(8'h10, 10);
        check("g3_tries",  32'(tries_left), 0);
        check("g3_locked", 32'(locked), 1);
        press(8'h33, 10);
        check("g4_guess",  32'(last_guess), 32'h0010);
        check("g4_tries",  32'(tries_left), 0);

        // New round, then a correct guess.
        pulse_new_round();
        check("nr1_tries",  32'(tries_left), 3);
        check("nr1_locked", 32'(locked), 0);
        check("nr1_guess",  32'(last_guess), 32'h0010);
        bingo_cnt = 0;
        press(8'hB5, 10);
        check("win_hints", {hint_hi, hint_lo}, 2'b11);
        check("win_won",   32'(won), 1);
        check("win_bingo_cycles", bingo_cnt, 1);
        pulse_new_round();
        check("nr2_tries", 32'(tries_left), 3);
        check("nr2_state", {won, hint_hi, hint_lo}, 3'b000);

        // Timeout coinciding with submit in READY: lock, guess not latched.
        sw = 8'h77; btn_n = 1'b0;
        wait_submit();
        timeout = 1'b1; tick(1); timeout = 1'b0;
        tick(4); btn_n = 1'b1; tick(SETTLE);
        check("tos_locked", 32'(locked), 1);
        check("tos_guess",  32'(last_guess), 32'h00B5);
        pulse_new_round();

        // Timeout during the verdict of a wrong guess: hints update, lock.
        sw = 8'h40; btn_n = 1'b0;
        wait_pending();
        timeout = 1'b1; tick(1); timeout = 1'b0;
        tick(4); btn_n = 1'b1; tick(SETTLE);
        check("toe_hints",  {hint_hi, hint_lo}, 2'b01);
        check("toe_locked", 32'(locked), 1);
        check("toe_tries",  32'(tries_left), 2);
        pulse_new_round();

        // Timeout during the verdict of a correct guess: win still wins.
        bingo_cnt = 0;
        sw = 8'hB5; btn_n = 1'b0;
        wait_pending();
        timeout = 1'b1; tick(1); timeout = 1'b0;
        tick(4); btn_n = 1'b1; tick(SETTLE);
        check("tow_won",    32'(won), 1);
        check("tow_locked", 32'(locked), 0);
        check("tow_bingo_cycles", bingo_cnt, 1);
        pulse_new_round();

        // new_round beats a simultaneous timeout.
        new_round = 1'b1; timeout = 1'b1; tick(1);
        new_round = 1'b0; timeout = 1'b0; tick(2);
        check("nrto_locked", 32'(locked), 0);
        check("nrto_tries",  32'(tries_left), 3);

        // Single-cycle glitch low.
        sw = 8'h20; btn_n = 1'b0; tick(1); btn_n = 1'b1;
`ifdef GUESS_CHECKER_DEBOUNCE_EN
        tick(SETTLE);
        check("glitch_tries", 32'(tries_left), 3);
        check("glitch_guess", 32'(last_guess), 32'h00B5);
`else
        tick(2);
        check("glitch_latch",  32'(last_guess), 32'h0020);
        check("glitch_tries0", 32'(tries_left), 3);
        tick(1);
        check("glitch_tries1", 32'(tries_left), 2);
        check("glitch_hints",  {hint_hi, hint_lo}, 2'b01);
        tick(SETTLE);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
